// File: rtl/clock_div_f2s_fifo_pkg.sv
// Shared constants and types for the fast-to-slow FIFO slice.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package clock_div_f2s_fifo_pkg;

  localparam int F2S_DATA_W_DEF = 8;
  localparam int F2S_INDX_W_DEF = 2;
  localparam int F2S_DEPTH_DEF  = 1 << F2S_INDX_W_DEF;

  // Per-edge events: accepted enqueue, accepted dequeue, slow-edge update.
  typedef struct packed {
    logic enq;
    logic deq;
    logic upd;
  } f2s_evt_t;

endpackage

// File: rtl/clock_div_f2s_fifo_mem.sv
// Register array: synchronous write, asynchronous read.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates wr_vld.
module clock_div_f2s_fifo_mem #(
  parameter int dataWidth = 8,
  parameter int depth     = 4,
  parameter int indxWidth = 2
) (
  input  logic                 CLK_IN,
  input  logic                 wr_vld,
  input  logic [indxWidth-1:0] wr_addr,
  input  logic [dataWidth-1:0] wr_dat,
  input  logic [indxWidth-1:0] rd_addr,
  output logic [dataWidth-1:0] rd_dat
);

  logic [dataWidth-1:0] mem_q [depth];
  logic [dataWidth-1:0] mem_d [depth];

  // Next array contents: overwrite one entry on a write.
  always_comb begin
    mem_d = mem_q;
    if (wr_vld) begin
      mem_d[wr_addr] = wr_dat;
    end
  end

  // Storage is deliberately not reset; only pointers define validity.
  always_ff @(posedge CLK_IN) begin
    mem_q <= mem_d;
  end

  assign rd_dat = mem_q[rd_addr];

endmodule

// File: rtl/clock_div_f2s_fifo.sv
// Fast-to-slow FIFO on CLK_IN; slow-side outputs only change at slow rising edges (upd).
// Latency: enqueue visible at the first upd edge strictly after the write edge.
// Backpressure: ENQ dropped while FULL_N=0; DEQ honoured only at upd edges with CLK_GATE=1.
module clock_div_f2s_fifo
  import clock_div_f2s_fifo_pkg::*;
#(
  parameter int dataWidth = F2S_DATA_W_DEF,
  parameter int depth     = F2S_DEPTH_DEF,
  parameter int indxWidth = F2S_INDX_W_DEF
) (
  input  logic                 CLK_IN,
  input  logic                 RST,
  input  logic                 PREEDGE,
  input  logic                 CLK_GATE,
  input  logic                 ENQ,
  input  logic [dataWidth-1:0] D_IN,
  output logic                 FULL_N,
  input  logic                 DEQ,
  output logic [dataWidth-1:0] D_OUT,
  output logic                 EMPTY_N
);

  localparam logic [indxWidth:0] DEPTH_CNT = depth[indxWidth:0];

  logic                 pe_q, pe_d;
  logic [indxWidth-1:0] head_q, head_d;
  logic [indxWidth-1:0] tail_q, tail_d;
  logic [indxWidth:0]   count_q, count_d;
  logic                 full_n_q, full_n_d;
  logic                 empty_n_q, empty_n_d;
  logic [dataWidth-1:0] d_out_q, d_out_d;

  f2s_evt_t             evt;
  logic [indxWidth-1:0] head_pop;
  logic [indxWidth:0]   count_pop;
  logic [dataWidth-1:0] rd_dat;

  // Accepted events this edge; a reset edge swallows both ENQ and DEQ.
  always_comb begin
    evt.upd   = pe_q;
    evt.enq   = ENQ & full_n_q & ~RST;
    evt.deq   = pe_q & DEQ & empty_n_q & CLK_GATE & ~RST;
    head_pop  = head_q + indxWidth'(evt.deq);
    count_pop = count_q - (indxWidth + 1)'(evt.deq);
  end

  clock_div_f2s_fifo_mem #(
    .dataWidth (dataWidth),
    .depth     (depth),
    .indxWidth (indxWidth)
  ) u_mem (
    .CLK_IN  (CLK_IN),
    .wr_vld  (evt.enq),
    .wr_addr (tail_q),
    .wr_dat  (D_IN),
    .rd_addr (head_pop),
    .rd_dat  (rd_dat)
  );

  // Next state: pointers/count every edge, slow-side snapshot only at upd.
  // The snapshot uses post-pop count and pre-write memory, so a same-edge
  // enqueue only becomes visible at the following upd edge.
  always_comb begin
    pe_d      = PREEDGE;
    head_d    = head_pop;
    tail_d    = tail_q + indxWidth'(evt.enq);
    count_d   = count_pop + (indxWidth + 1)'(evt.enq);
    full_n_d  = (count_d < DEPTH_CNT);
    empty_n_d = empty_n_q;
    d_out_d   = d_out_q;
    if (evt.upd) begin
      empty_n_d = (count_pop != '0);
      d_out_d   = rd_dat;
    end
    if (RST) begin
      pe_d      = 1'b0;
      head_d    = '0;
      tail_d    = '0;
      count_d   = '0;
      full_n_d  = 1'b1;
      empty_n_d = 1'b0;
      d_out_d   = '0;
    end
  end

  // State register; reset is folded into the _d terms above.
  always_ff @(posedge CLK_IN) begin
    pe_q      <= pe_d;
    head_q    <= head_d;
    tail_q    <= tail_d;
    count_q   <= count_d;
    full_n_q  <= full_n_d;
    empty_n_q <= empty_n_d;
    d_out_q   <= d_out_d;
  end

  assign FULL_N  = full_n_q;
  assign EMPTY_N = empty_n_q;
  assign D_OUT   = d_out_q;

endmodule

// File: tb/tb_clock_div_f2s_fifo.sv
// Directed bench for clock_div_f2s_fifo with a divide-by-3 PREEDGE pattern.
// Latency: n/a.
// Backpressure: n/a.
module tb_clock_div_f2s_fifo;

  logic       CLK_IN;
  logic       RST;
  logic       PREEDGE;
  logic       CLK_GATE;
  logic       ENQ;
  logic [7:0] D_IN;
  logic       FULL_N;
  logic       DEQ;
  logic [7:0] D_OUT;
  logic       EMPTY_N;

  int checks;
  int failures;

  clock_div_f2s_fifo #(
    .dataWidth (8),
    .depth     (4),
    .indxWidth (2)
  ) dut (
    .CLK_IN   (CLK_IN),
    .RST      (RST),
    .PREEDGE  (PREEDGE),
    .CLK_GATE (CLK_GATE),
    .ENQ      (ENQ),
    .D_IN     (D_IN),
    .FULL_N   (FULL_N),
    .DEQ      (DEQ),
    .D_OUT    (D_OUT),
    .EMPTY_N  (EMPTY_N)
  );

  initial begin
    CLK_IN = 1'b0;
    forever #5 CLK_IN = ~CLK_IN;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it.
  task automatic step(input logic pe, input logic gate, input logic enq,
                      input logic [7:0] din, input logic deq);
    PREEDGE  = pe;
    CLK_GATE = gate;
    ENQ      = enq;
    D_IN     = din;
    DEQ      = deq;
    @(posedge CLK_IN);
    #1;
  endtask

  // One slow period; its last edge is an upd edge.
  task automatic slow3(input logic gate, input logic deq);
    step(1'b0, gate, 1'b0, 8'h00, deq);
    step(1'b1, gate, 1'b0, 8'h00, deq);
    step(1'b0, gate, 1'b0, 8'h00, deq);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    RST      = 1'b1;
    PREEDGE  = 1'b0;
    CLK_GATE = 1'b1;
    ENQ      = 1'b0;
    D_IN     = 8'h00;
    DEQ      = 1'b0;

    // Reset held 3 cycles with ENQ asserted.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    chk("rst_full_n", 32'(FULL_N), 1);
    chk("rst_empty_n", 32'(EMPTY_N), 0);
    chk("rst_d_out", 32'(D_OUT), 0);
    RST = 1'b0;
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);  // upd edge
    chk("rst_enq_not_stored", 32'(EMPTY_N), 0);
    chk("rst_full_n_after", 32'(FULL_N), 1);

    // Single item, divide-by-3, upd edges at 3, 6, 9; enqueue on upd edge 3.
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);  // 1
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);  // 2
    step(1'b0, 1'b1, 1'b1, 8'h5A, 1'b0);  // 3 upd + enq
    chk("single_same_edge_hidden", 32'(EMPTY_N), 0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);  // 4
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b0);  // 5
    chk("single_hold_between_upd", 32'(EMPTY_N), 0);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);  // 6 upd
    chk("single_empty_n_e6", 32'(EMPTY_N), 1);
    chk("single_d_out_e6", 32'(D_OUT), 32'h5A);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);  // 7
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);  // 8
    chk("single_no_pop_off_upd", 32'(EMPTY_N), 1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);  // 9 upd, pop
    chk("single_popped_e9", 32'(EMPTY_N), 0);

    // Fill with 4 back-to-back writes, 5th dropped.
    step(1'b0, 1'b1, 1'b1, 8'h01, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h02, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h03, 1'b0);
    chk("fill_full_n_3", 32'(FULL_N), 1);
    step(1'b0, 1'b1, 1'b1, 8'h04, 1'b0);
    chk("fill_full_n_4", 32'(FULL_N), 0);
    step(1'b0, 1'b1, 1'b1, 8'h05, 1'b0);
    chk("fill_5th_full_n", 32'(FULL_N), 0);
    chk("fill_no_upd_empty_n", 32'(EMPTY_N), 0);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);  // upd: snapshot only
    chk("drain_d_out_01", 32'(D_OUT), 32'h01);
    chk("drain_full_still", 32'(FULL_N), 0);
    // Full + simultaneous ENQ/DEQ on an upd edge: pop wins, enqueue dropped.
    step(1'b0, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b1, 1'b1, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b1, 1'b1, 8'h06, 1'b1);
    chk("simul_full_n", 32'(FULL_N), 1);
    chk("drain_d_out_02", 32'(D_OUT), 32'h02);
    slow3(1'b1, 1'b1);
    chk("drain_d_out_03", 32'(D_OUT), 32'h03);
    chk("drain_empty_n_03", 32'(EMPTY_N), 1);
    slow3(1'b1, 1'b1);
    chk("drain_d_out_04", 32'(D_OUT), 32'h04);
    chk("drain_empty_n_04", 32'(EMPTY_N), 1);
    slow3(1'b1, 1'b1);
    chk("drain_done_empty_n", 32'(EMPTY_N), 0);
    chk("drain_done_full_n", 32'(FULL_N), 1);

    // Gate low for 2 slow periods with 2 entries and DEQ held.
    step(1'b0, 1'b1, 1'b1, 8'h11, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h22, 1'b0);
    slow3(1'b1, 1'b0);
    chk("gate_pre_empty_n", 32'(EMPTY_N), 1);
    chk("gate_pre_d_out", 32'(D_OUT), 32'h11);
    slow3(1'b0, 1'b1);
    chk("gate_off1_d_out", 32'(D_OUT), 32'h11);
    slow3(1'b0, 1'b1);
    chk("gate_off2_d_out", 32'(D_OUT), 32'h11);
    chk("gate_off2_empty_n", 32'(EMPTY_N), 1);
    slow3(1'b1, 1'b1);
    chk("gate_resume_d_out", 32'(D_OUT), 32'h22);
    chk("gate_resume_empty_n", 32'(EMPTY_N), 1);
    slow3(1'b1, 1'b1);
    chk("gate_drained", 32'(EMPTY_N), 0);

    // Mid-operation reset with 3 entries, then a fresh item.
    step(1'b0, 1'b1, 1'b1, 8'h31, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h32, 1'b0);
    step(1'b0, 1'b1, 1'b1, 8'h33, 1'b0);
    slow3(1'b1, 1'b0);
    chk("mid_pre_d_out", 32'(D_OUT), 32'h31);
    chk("mid_pre_empty_n", 32'(EMPTY_N), 1);
    RST = 1'b1;
    step(1'b0, 1'b1, 1'b1, 8'h99, 1'b1);
    chk("mid_rst_empty_n", 32'(EMPTY_N), 0);
    chk("mid_rst_full_n", 32'(FULL_N), 1);
    chk("mid_rst_d_out", 32'(D_OUT), 0);
    RST = 1'b0;
    step(1'b0, 1'b1, 1'b1, 8'h77, 1'b0);
    slow3(1'b1, 1'b0);
    chk("mid_after_empty_n", 32'(EMPTY_N), 1);
    chk("mid_after_d_out", 32'(D_OUT), 32'h77);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
